// File: rtl/pc_fetch_pkg.sv
// Shared types and default constants for the fetch-PC controller.
// Consumed by pc_fetch_ctrl and fetch_halt_fsm.
package pc_fetch_pkg;

  localparam int PC_W = 32;

  localparam logic [PC_W-1:0] DEFAULT_RESET_PC     = 32'h0000_0000;
  localparam int              DEFAULT_PC_STEP      = 4;
  localparam int              DEFAULT_DRAIN_CYCLES = 3;

  // Low address bits that must be zero for a word-aligned fetch target.
  localparam logic [PC_W-1:0] PC_ALIGN_MASK = 32'h0000_0003;

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_HALTING = 2'b01,
    ST_HALTED  = 2'b10
  } fetch_state_e;

  // $clog2(cycles+1) collapses to zero bits when cycles==0; keep one bit.
  function automatic int drain_cnt_w(input int cycles);
    return (cycles > 0) ? $clog2(cycles + 1) : 1;
  endfunction

endpackage

// File: rtl/fetch_halt_fsm.sv
// RUN / HALTING / HALTED sequencer with the pipeline drain counter.
// Once HALTED, only reset brings the controller back to RUN.
module fetch_halt_fsm
  import pc_fetch_pkg::*;
#(
  parameter int DRAIN_CYCLES = DEFAULT_DRAIN_CYCLES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         halt_req,
  input  logic         stall,
  output fetch_state_e state,
  output logic         halted
);

  localparam int               CNT_W    = drain_cnt_w(DRAIN_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

  fetch_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_RUN: begin
        if (halt_req && !stall) begin
          if (DRAIN_CYCLES == 0) begin
            state_d = ST_HALTED;
          end else begin
            state_d = ST_HALTING;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      // Drain proceeds even while the pipeline is stalled.
      ST_HALTING: begin
        if (cnt_q == '0) state_d = ST_HALTED;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = ST_HALTED;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state  = state_q;
  assign halted = (state_q == ST_HALTED);

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch-PC controller: sequential fetch, branch redirect/squash, halt drain.
// Optional PC_ALIGN_CHECK_EN: misaligned redirect targets raise a sticky fault and halt.
module pc_fetch_ctrl
  import pc_fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC     = DEFAULT_RESET_PC,
  parameter int              PC_STEP      = DEFAULT_PC_STEP,
  parameter int              DRAIN_CYCLES = DEFAULT_DRAIN_CYCLES
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] new_pc,
  input  logic            dont_squash_dec_in,
  input  logic            dont_squash_exec_in,
  input  logic            halt_proc,
  output logic [PC_W-1:0] fetch_pc,
  output logic [PC_W-1:0] inst_pc,
  output logic            inst_valid,
  output logic            branch_squash,
  output logic            dont_squash_dec,
  output logic            dont_squash_exec,
  output logic            halted,
  output logic            misalign_fault
);

  fetch_state_e    state;
  logic            run_go;
  logic            redirect;
  logic            misaligned;
  logic [PC_W-1:0] redirect_target;

  logic [PC_W-1:0] fetch_pc_q,   fetch_pc_d;
  logic [PC_W-1:0] inst_pc_q,    inst_pc_d;
  logic            inst_valid_q, inst_valid_d;

  // A simultaneous halt request beats the branch.
  assign run_go          = (state == ST_RUN) && !stall;
  assign redirect        = run_go && branch_taken && !halt_proc;
  assign redirect_target = new_pc & ~PC_ALIGN_MASK;

  assign branch_squash    = redirect;
  assign dont_squash_dec  = dont_squash_dec_in  & redirect;
  assign dont_squash_exec = dont_squash_exec_in & redirect;

`ifdef PC_ALIGN_CHECK_EN
  logic misalign_fault_q, misalign_fault_d;

  assign misaligned       = redirect && ((new_pc & PC_ALIGN_MASK) != '0);
  assign misalign_fault_d = misalign_fault_q | misaligned;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) misalign_fault_q <= 1'b0;
    else      misalign_fault_q <= misalign_fault_d;
  end

  assign misalign_fault = misalign_fault_q;
`else
  assign misaligned     = 1'b0;
  assign misalign_fault = 1'b0;
`endif

  fetch_halt_fsm #(
    .DRAIN_CYCLES(DRAIN_CYCLES)
  ) u_halt_fsm (
    .clk     (clk),
    .rst     (rst),
    .halt_req(halt_proc | misaligned),
    .stall   (stall),
    .state   (state),
    .halted  (halted)
  );

  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;
    if (state != ST_RUN) begin
      inst_valid_d = 1'b0;
    end else if (run_go) begin
      if (halt_proc || misaligned) begin
        inst_valid_d = 1'b0;
      end else if (redirect) begin
        // The instruction fetched this cycle is wrong-path: capture it as a bubble.
        fetch_pc_d   = redirect_target;
        inst_pc_d    = fetch_pc_q;
        inst_valid_d = 1'b0;
      end else begin
        fetch_pc_d   = fetch_pc_q + PC_W'(PC_STEP);
        inst_pc_d    = fetch_pc_q;
        inst_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q   <= RESET_PC;
      inst_pc_q    <= RESET_PC;
      inst_valid_q <= 1'b0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
    end
  end

  assign fetch_pc   = fetch_pc_q;
  assign inst_pc    = inst_pc_q;
  assign inst_valid = inst_valid_q;

endmodule

// File: doc/pc_fetch_ctrl.md
PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 Parameters (name, default, meaning) SHALL be as follows.
- RESET_PC, 32'h0000_0000, fetch address loaded at reset.
- PC_STEP, 4, byte increment per sequential fetch.
- DRAIN_CYCLES, 3, cycles spent in HALTING before HALTED.
REQ-002 Ports (name, direction, width, meaning) SHALL be as follows; there is one clock, and reset is asynchronous, active-low.
- clk, in, 1, single clock.
- rst, in, 1, asynchronous active-low reset.
- stall, in, 1, global pipeline stall.
- branch_taken, in, 1, redirect request from the branch pipeline EX stage.
- new_pc, in, 32, redirect target.
- dont_squash_dec_in, in, 1, branch pipeline request to spare the decode-stage instruction.
- dont_squash_exec_in, in, 1, branch pipeline request to spare the execute-stage instructions.
- halt_proc, in, 1, halt request from the branch pipeline.
- fetch_pc, out, 32, address presented to instruction memory.
- inst_pc, out, 32, PC of the instruction in the inst register.
- inst_valid, out, 1, inst register holds a live instruction.
- branch_squash, out, 1, squash to all pipelines.
- dont_squash_dec, out, 1, forwarded spare-decode qualifier.
- dont_squash_exec, out, 1, forwarded spare-exec qualifier.
- halted, out, 1, processor fully halted.
- misalign_fault, out, 1, sticky fault for an unaligned redirect target.

Function
REQ-003 The block SHALL have FSM states RUN, HALTING and HALTED, held in a 2-bit encoding.
REQ-004 In RUN with stall=0 and no redirect, the update SHALL be fetch_pc <= fetch_pc + PC_STEP (mod 2^32, wraps 32'hFFFF_FFFC -> 0), inst_pc <= fetch_pc, inst_valid <= 1.
REQ-005 With stall=1, fetch_pc, inst_pc, inst_valid and the FSM state SHALL all hold.
REQ-006 redirect = branch_taken & ~stall & (state==RUN); branch redirects SHALL be deferred while stall=1 and SHALL be ignored outside RUN.
REQ-007 On redirect, the update SHALL be fetch_pc <= new_pc, inst_pc <= fetch_pc, inst_valid <= 0 (one bubble cycle for the wrong-path fetch).
REQ-008 branch_squash SHALL equal redirect, combinationally in the same cycle.
REQ-009 dont_squash_dec and dont_squash_exec SHALL equal their inputs ANDed with redirect, combinationally.
REQ-010 halt_proc & ~stall in RUN SHALL move the FSM to HALTING, load the drain counter with DRAIN_CYCLES-1, freeze fetch_pc and force inst_valid <= 0.
REQ-011 If halt_proc and branch_taken are both asserted in RUN, halt SHALL win: no redirect and branch_squash=0.
REQ-012 In HALTING, the drain counter SHALL decrement each cycle regardless of stall; at 0 the FSM SHALL enter HALTED.
REQ-013 HALTED SHALL be left only by reset, with halted=1, inst_valid=0, fetch_pc frozen and all inputs ignored.
REQ-014 The drain counter width SHALL be $clog2(DRAIN_CYCLES+1), and DRAIN_CYCLES=0 SHALL go from RUN directly to HALTED.

Reset
REQ-015 While rst=0, the block SHALL asynchronously force state=RUN, fetch_pc=RESET_PC, inst_pc=RESET_PC, inst_valid=0, halted=0, misalign_fault=0 and drain counter=0.
REQ-016 The first fetch_pc increment SHALL occur on the first rising clk after rst deasserts with stall=0.
REQ-017 Reset asserted mid-HALTING or mid-redirect SHALL override everything immediately.

Configuration
REQ-018 With PC_ALIGN_CHECK_EN defined, a redirect with new_pc[1:0]!=0 SHALL set misalign_fault (sticky) and enter HALTING instead of redirecting; branch_squash SHALL remain asserted for that cycle.
REQ-019 Without PC_ALIGN_CHECK_EN, fetch_pc SHALL load {new_pc[31:2],2'b00} and misalign_fault SHALL be tied to 0.

Structure
REQ-020 Package pc_fetch_pkg SHALL hold the FSM state enum, the default RESET_PC, PC_STEP and DRAIN_CYCLES constants, and the PC width localparam.
REQ-021 The FSM plus drain counter SHALL be one sub-module, fetch_halt_fsm, with inputs halt_req and stall and outputs state and halted; PC datapath logic SHALL remain in pc_fetch_ctrl.

Verification
REQ-022 The bench SHALL cover the following directed scenarios.
- Reset, stall=0 for 4 cycles -> fetch_pc 0,4,8,12; inst_pc lags by 1; inst_valid=1 from cycle 2.
- branch_taken=1 with new_pc=32'h100 at fetch_pc=8 -> branch_squash=1 that cycle; next fetch_pc=32'h100, inst_valid=0; then 32'h104, inst_valid=1.
- branch_taken=1 with stall=1 for 2 cycles, then stall=0 -> branch_squash=0 while stalled; redirect on the first unstalled cycle.
- halt_proc and branch_taken both 1 -> branch_squash=0; halted=1 after exactly DRAIN_CYCLES (3) cycles; fetch_pc frozen; later branch_taken ignored.
- fetch_pc=32'hFFFF_FFFC -> next fetch_pc=0.
- new_pc=32'h102 -> with PC_ALIGN_CHECK_EN, misalign_fault=1 and halted after 3 cycles; without it, fetch_pc=32'h100.
